serial_input_receiver: RTL and testbench
========================================

SERIAL_INPUT_RECEIVER -- requirements
Module: serial_input_receiver

Interface
REQ-001 The module SHALL have the parameter WORD_W, default 16, giving the serial word length in bits (MSB first).
REQ-002 The module SHALL have the parameter ZERO_RUN, default 800, giving the number of consecutive zero words that declares a channel silent.
REQ-003 Port Dclk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port Reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port Frame, input, 1: high for one Dclk cycle, coincident with the MSB of each word.
REQ-006 Port InputL, input, 1: left-channel serial data bit.
REQ-007 Port InputR, input, 1: right-channel serial data bit.
REQ-008 Port data_L, output, WORD_W: last complete left word.
REQ-009 Port data_R, output, WORD_W: last complete right word.
REQ-010 Port input_ready, output, 1: one-cycle pulse when data_L and data_R are updated.
REQ-011 Port allzeros_L, output, 1: left channel has received at least ZERO_RUN consecutive zero words.
REQ-012 Port allzeros_R, output, 1: right channel has received at least ZERO_RUN consecutive zero words.
REQ-013 Port frame_err, output, 1: one-cycle pulse when Frame arrives while a word is incomplete.

Function
REQ-014 The FSM SHALL have two states: IDLE and RECV.
REQ-015 In IDLE, Frame=1 SHALL sample InputL/InputR into bit WORD_W-1 of the shift registers, load bit_cnt=WORD_W-2, and move the FSM to RECV.
REQ-016 In RECV with Frame=0, each cycle SHALL shift one bit per channel into position bit_cnt and decrement bit_cnt.
REQ-017 When bit 0 is sampled, the next edge SHALL load data_L/data_R, assert input_ready for exactly one cycle, and return the FSM to IDLE.
REQ-018 Latency SHALL be one Dclk from the bit-0 sampling edge to input_ready=1.
REQ-019 A Frame in the cycle immediately after bit 0 SHALL start the next word with no lost cycle, so back-to-back words are supported.
REQ-020 Frame=1 in RECV with bit_cnt>0 SHALL discard the partial word, pulse frame_err, and restart reception at bit WORD_W-1 with the current bit.
REQ-021 A discarded word SHALL NOT assert input_ready and SHALL NOT change the zero counters.
REQ-022 Each channel SHALL keep a zero-run counter, ceil(log2(ZERO_RUN+1)) bits wide, that increments on each completed all-zero word and saturates at ZERO_RUN.
REQ-023 A completed nonzero word SHALL clear that channel's counter to 0.
REQ-024 allzeros_X SHALL be registered and equal (counter_X == ZERO_RUN); it asserts on the input_ready edge of the ZERO_RUN-th zero word and deasserts on the input_ready edge of the first nonzero word.
REQ-025 data_L/data_R SHALL hold their values between input_ready pulses.

Reset
REQ-026 Reset_n=0 SHALL asynchronously force: FSM=IDLE, bit_cnt=0, shift registers=0, data_L=data_R=0, input_ready=0, frame_err=0, zero counters=0, allzeros_L=allzeros_R=0.
REQ-027 A reset asserted mid-word SHALL discard the partial word; reception resumes only on the next Frame after Reset_n=1.

Configuration
REQ-028 The macro ZERO_DETECT_EN SHALL control the zero-run detector.
REQ-029 With ZERO_DETECT_EN defined, the zero-run counters and allzeros logic SHALL be compiled in per REQ-022..024.
REQ-030 Without ZERO_DETECT_EN, the counters SHALL be absent and allzeros_L=allzeros_R=0 constantly; all other behaviour is unchanged.

Verification
REQ-031 Frame + 16 bits, L=16'hA5C3, R=16'h0001 -> input_ready pulse 1 Dclk after the bit-0 edge; data_L=A5C3, data_R=0001; frame_err=0.
REQ-032 Back-to-back words 16'h1234, 16'h5678 on both channels -> two input_ready pulses 16 cycles apart; final data=5678.
REQ-033 Frame reasserted after 7 bits, then a full word 16'hBEEF -> frame_err pulse; single input_ready; data=BEEF.
REQ-034 (ZERO_DETECT_EN) 799 zero words on L -> allzeros_L=0; 800th -> allzeros_L=1; next word 16'h0004 -> allzeros_L=0; R nonzero throughout -> allzeros_R=0.
REQ-035 Reset_n low at bit 9 of a word -> all outputs 0 immediately; no input_ready until the next Frame plus 16 bits.
REQ-036 (without ZERO_DETECT_EN) 1000 zero words -> allzeros_L=allzeros_R=0 throughout; data=0000 with 1000 input_ready pulses.

Source files
------------

// File: rtl/serial_input_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_input_receiver
//  Description : Two-channel (left/right) MSB-first serial word receiver.
//                A one-cycle Frame pulse marks the MSB of each word. Both
//                channels are shifted in together. The completed words are
//                published on data_L/data_R with a one-cycle input_ready
//                pulse. Words can arrive back to back.
//
//                A Frame that arrives while a word is still incomplete
//                discards the partial word. It pulses frame_err and restarts
//                reception with the current bit as the MSB.
//
//                Optional zero-run detector, enabled by the macro
//                ZERO_DETECT_EN: allzeros_X is raised once a channel has
//                delivered ZERO_RUN consecutive all-zero words. It is cleared
//                by the first nonzero word. When the macro is undefined,
//                allzeros_L and allzeros_R are tied low.
//
//  Parameters  : WORD_W   - serial word length in bits (>= 2)
//                ZERO_RUN - consecutive zero words that mark a channel silent
//
//  Ports       : Dclk        in   clock, rising edge
//                Reset_n     in   asynchronous active-low reset
//                Frame       in   one-cycle pulse coincident with each MSB
//                InputL      in   left-channel serial bit
//                InputR      in   right-channel serial bit
//                data_L      out  last complete left word
//                data_R      out  last complete right word
//                input_ready out  one-cycle pulse when data_L/data_R update
//                allzeros_L  out  left channel silent (zero-run detector)
//                allzeros_R  out  right channel silent (zero-run detector)
//                frame_err   out  one-cycle pulse on a premature Frame
//
//  Revision    : 1.0  initial release
// ============================================================================
module serial_input_receiver #(
  parameter int WORD_W   = 16,
  parameter int ZERO_RUN = 800
) (
  input  logic              Dclk,
  input  logic              Reset_n,
  input  logic              Frame,
  input  logic              InputL,
  input  logic              InputR,
  output logic [WORD_W-1:0] data_L,
  output logic [WORD_W-1:0] data_R,
  output logic              input_ready,
  output logic              allzeros_L,
  output logic              allzeros_R,
  output logic              frame_err
);

  // bit_cnt only ever holds WORD_W-2 .. 0
  localparam int                 c_CNT_W     = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_START = c_CNT_W'(WORD_W - 2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [WORD_W-1:0]  r_shift_l;
  logic [WORD_W-1:0]  r_shift_r;
  logic               r_word_done;   // bit 0 was sampled on the previous edge
  logic [WORD_W-1:0]  r_data_l;
  logic [WORD_W-1:0]  r_data_r;
  logic               r_input_ready;
  logic               r_frame_err;

  // --------------------------------------------------------------------------
  // Reception FSM.
  // The FSM drops back to IDLE on the same edge that samples bit 0. It also
  // raises r_word_done, and the word is published on the following edge.
  // Because of this, a Frame in the cycle right after bit 0 is seen in IDLE
  // and starts the next word with no gap.
  // --------------------------------------------------------------------------
  always_ff @(posedge Dclk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift_l   <= '0;
      r_shift_r   <= '0;
      r_word_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Frame) begin
            r_shift_l[WORD_W-1] <= InputL;
            r_shift_r[WORD_W-1] <= InputR;
            r_bit_cnt           <= c_BIT_START;
            r_state             <= S_RECV;
          end
        end
        S_RECV: begin
          if (Frame) begin
            // Premature frame: abandon the partial word, restart at the MSB
            r_frame_err         <= 1'b1;
            r_shift_l[WORD_W-1] <= InputL;
            r_shift_r[WORD_W-1] <= InputR;
            r_bit_cnt           <= c_BIT_START;
          end else begin
            r_shift_l[r_bit_cnt] <= InputL;
            r_shift_r[r_bit_cnt] <= InputR;
            if (r_bit_cnt == '0) begin
              r_word_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt - c_CNT_ONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output word registers. On the publish edge, the shift registers still
  // hold the finished word, even if a new Frame loads the MSB on that same
  // edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge Dclk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data_l      <= '0;
      r_data_r      <= '0;
      r_input_ready <= 1'b0;
    end else begin
      r_input_ready <= r_word_done;
      if (r_word_done) begin
        r_data_l <= r_shift_l;
        r_data_r <= r_shift_r;
      end
    end
  end

  assign data_L      = r_data_l;
  assign data_R      = r_data_r;
  assign input_ready = r_input_ready;
  assign frame_err   = r_frame_err;

`ifdef ZERO_DETECT_EN
  // --------------------------------------------------------------------------
  // Zero-run detector. The counters advance only on published words, so
  // discarded partial words never affect them.
  // --------------------------------------------------------------------------
  localparam int                  c_ZCNT_W   = $clog2(ZERO_RUN + 1);
  localparam logic [c_ZCNT_W-1:0] c_ZERO_RUN = c_ZCNT_W'(ZERO_RUN);
  localparam logic [c_ZCNT_W-1:0] c_ZONE     = c_ZCNT_W'(1);

  logic [c_ZCNT_W-1:0] r_zcnt_l;
  logic [c_ZCNT_W-1:0] r_zcnt_r;
  logic [c_ZCNT_W-1:0] w_zcnt_l_next;
  logic [c_ZCNT_W-1:0] w_zcnt_r_next;
  logic                r_allzeros_l;
  logic                r_allzeros_r;

  // Counter value after the word now sitting in the shift register is
  // published: saturating increment on zero, clear on nonzero.
  always_comb begin
    w_zcnt_l_next = r_zcnt_l;
    if (r_shift_l != '0) begin
      w_zcnt_l_next = '0;
    end else if (r_zcnt_l != c_ZERO_RUN) begin
      w_zcnt_l_next = r_zcnt_l + c_ZONE;
    end

    w_zcnt_r_next = r_zcnt_r;
    if (r_shift_r != '0) begin
      w_zcnt_r_next = '0;
    end else if (r_zcnt_r != c_ZERO_RUN) begin
      w_zcnt_r_next = r_zcnt_r + c_ZONE;
    end
  end

  // The flags are computed from the next counter value. This lets them
  // change on the same edge as input_ready.
  always_ff @(posedge Dclk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_zcnt_l     <= '0;
      r_zcnt_r     <= '0;
      r_allzeros_l <= 1'b0;
      r_allzeros_r <= 1'b0;
    end else if (r_word_done) begin
      r_zcnt_l     <= w_zcnt_l_next;
      r_zcnt_r     <= w_zcnt_r_next;
      r_allzeros_l <= (w_zcnt_l_next == c_ZERO_RUN);
      r_allzeros_r <= (w_zcnt_r_next == c_ZERO_RUN);
    end
  end

  assign allzeros_L = r_allzeros_l;
  assign allzeros_R = r_allzeros_r;
`else
  // Detector not built: ZERO_RUN is accepted for interface compatibility only
  logic w_unused_zero_run;
  assign w_unused_zero_run = (ZERO_RUN == 0);

  assign allzeros_L = 1'b0;
  assign allzeros_R = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_input_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_input_receiver
//  Description : Scoreboard bench for serial_input_receiver. Each sent word
//                pushes its expected data and expected ready cycle. A monitor
//                pops and compares them on every input_ready pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_input_receiver;

  localparam int W  = 16;
  localparam int ZR = 800;

  logic         Dclk    = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Frame   = 1'b0;
  logic         InputL  = 1'b0;
  logic         InputR  = 1'b0;
  logic [W-1:0] data_L;
  logic [W-1:0] data_R;
  logic         input_ready;
  logic         allzeros_L;
  logic         allzeros_R;
  logic         frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_ready  = 0;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           due;
  } exp_t;

  exp_t sb[$];

  serial_input_receiver #(
    .WORD_W  (W),
    .ZERO_RUN(ZR)
  ) dut (
    .Dclk       (Dclk),
    .Reset_n    (Reset_n),
    .Frame      (Frame),
    .InputL     (InputL),
    .InputR     (InputR),
    .data_L     (data_L),
    .data_R     (data_R),
    .input_ready(input_ready),
    .allzeros_L (allzeros_L),
    .allzeros_R (allzeros_R),
    .frame_err  (frame_err)
  );

  always #5 Dclk = ~Dclk;

  always @(posedge Dclk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(posedge Dclk) begin : p_monitor
    exp_t e;
    #1;
    if (input_ready === 1'b1) begin
      n_ready++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL spurious_ready: input_ready=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc != e.due) begin
          failures++;
          $display("FAIL ready_latency: pulse at cycle %0d, expected cycle %0d", cyc, e.due);
        end
        checks++;
        if (data_L !== e.l || data_R !== e.r) begin
          failures++;
          $display("FAIL ready_data: L=%h R=%h, expected L=%h R=%h", data_L, data_R, e.l, e.r);
        end
      end
    end
  end

  task automatic send_bit(input logic f, input logic l, input logic r);
    Frame  = f;
    InputL = l;
    InputR = r;
    @(posedge Dclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0);
  endtask

  // Sends a full word; fe returns frame_err as seen right after the MSB edge
  task automatic send_word(input logic [W-1:0] l, input logic [W-1:0] r, output logic fe);
    exp_t e;
    fe = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(i == W - 1, l[i], r[i]);
      if (i == W - 1) fe = frame_err;
    end
    e.l   = l;
    e.r   = r;
    e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_ready: %0d words pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    idle(3);
    checks++;
    if ({data_L, data_R, input_ready, frame_err, allzeros_L, allzeros_R} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: L=%h R=%h rdy=%b fe=%b azL=%b azR=%b, expected all 0",
               data_L, data_R, input_ready, frame_err, allzeros_L, allzeros_R);
    end
    Reset_n = 1'b1;
    idle(3);
    checks++;
    if ({data_L, data_R, input_ready, frame_err} !== '0) begin
      failures++;
      $display("FAIL reset_idle: L=%h R=%h rdy=%b fe=%b, expected all 0",
               data_L, data_R, input_ready, frame_err);
    end
  endtask

  task automatic test_basic();
    logic fe;
    send_word(16'hA5C3, 16'h0001, fe);
    checks++;
    if (fe !== 1'b0) begin
      failures++;
      $display("FAIL basic_frame_err: got %b expected 0", fe);
    end
    drain("basic");
    checks++;
    if (data_L !== 16'hA5C3 || data_R !== 16'h0001) begin
      failures++;
      $display("FAIL basic_data: L=%h R=%h expected A5C3 0001", data_L, data_R);
    end
  endtask

  task automatic test_back_to_back();
    logic fe;
    int   n0;
    n0 = n_ready;
    send_word(16'h1234, 16'h1234, fe);
    send_word(16'h5678, 16'h5678, fe);
    checks++;
    if (fe !== 1'b0) begin
      failures++;
      $display("FAIL b2b_frame_err: got %b expected 0", fe);
    end
    drain("b2b");
    checks++;
    if (n_ready - n0 != 2) begin
      failures++;
      $display("FAIL b2b_pulse_count: got %0d expected 2", n_ready - n0);
    end
    idle(5);
    checks++;
    if (data_L !== 16'h5678 || data_R !== 16'h5678) begin
      failures++;
      $display("FAIL b2b_hold: L=%h R=%h expected 5678 5678", data_L, data_R);
    end
  endtask

  task automatic test_frame_err();
    logic fe;
    int   n0;
    n0 = n_ready;
    send_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1, 1'b1);
    send_word(16'hBEEF, 16'hBEEF, fe);
    checks++;
    if (fe !== 1'b1) begin
      failures++;
      $display("FAIL ferr_pulse: got %b expected 1", fe);
    end
    drain("ferr");
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL ferr_clear: got %b expected 0", frame_err);
    end
    checks++;
    if (n_ready - n0 != 1) begin
      failures++;
      $display("FAIL ferr_pulse_count: got %0d expected 1", n_ready - n0);
    end
    checks++;
    if (data_L !== 16'hBEEF || data_R !== 16'hBEEF) begin
      failures++;
      $display("FAIL ferr_data: L=%h R=%h expected BEEF BEEF", data_L, data_R);
    end
  endtask

  task automatic test_reset_mid();
    logic fe;
    logic [W-1:0] w;
    w = 16'hFFFF;
    send_bit(1'b1, w[15], w[15]);
    for (int i = 14; i >= 10; i--) send_bit(1'b0, w[i], w[i]);
    Frame  = 1'b0;
    InputL = w[9];
    InputR = w[9];
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({data_L, data_R, input_ready, frame_err, allzeros_L, allzeros_R} !== '0) begin
      failures++;
      $display("FAIL midreset_async: L=%h R=%h rdy=%b fe=%b azL=%b azR=%b, expected all 0",
               data_L, data_R, input_ready, frame_err, allzeros_L, allzeros_R);
    end
    @(posedge Dclk);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b1, 1'b1);
    checks++;
    if (data_L !== '0 || data_R !== '0) begin
      failures++;
      $display("FAIL midreset_no_resume: L=%h R=%h expected 0000 0000", data_L, data_R);
    end
    send_word(16'h1357, 16'h2468, fe);
    drain("midreset");
    checks++;
    if (data_L !== 16'h1357 || data_R !== 16'h2468) begin
      failures++;
      $display("FAIL midreset_data: L=%h R=%h expected 1357 2468", data_L, data_R);
    end
  endtask

`ifdef ZERO_DETECT_EN
  task automatic test_zero_run();
    logic fe;
    for (int k = 0; k < ZR - 1; k++) send_word(16'h0000, 16'h0001, fe);
    idle(1);
    checks++;
    if (allzeros_L !== 1'b0 || allzeros_R !== 1'b0) begin
      failures++;
      $display("FAIL zero_799: azL=%b azR=%b expected 0 0", allzeros_L, allzeros_R);
    end
    send_word(16'h0000, 16'h0001, fe);
    idle(1);
    checks++;
    if (allzeros_L !== 1'b1 || allzeros_R !== 1'b0) begin
      failures++;
      $display("FAIL zero_800: azL=%b azR=%b expected 1 0", allzeros_L, allzeros_R);
    end
    send_word(16'h0004, 16'h0001, fe);
    idle(1);
    checks++;
    if (allzeros_L !== 1'b0 || allzeros_R !== 1'b0) begin
      failures++;
      $display("FAIL zero_clear: azL=%b azR=%b expected 0 0", allzeros_L, allzeros_R);
    end
    drain("zero");
  endtask
`else
  task automatic test_zero_run();
    logic fe;
    int   n0;
    int   bad;
    n0  = n_ready;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      send_word(16'h0000, 16'h0000, fe);
      if (allzeros_L !== 1'b0 || allzeros_R !== 1'b0) bad++;
    end
    drain("zero");
    if (allzeros_L !== 1'b0 || allzeros_R !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL zero_flags: %0d samples with allzeros set, expected 0", bad);
    end
    checks++;
    if (n_ready - n0 != 1000) begin
      failures++;
      $display("FAIL zero_pulse_count: got %0d expected 1000", n_ready - n0);
    end
    checks++;
    if (data_L !== 16'h0000 || data_R !== 16'h0000) begin
      failures++;
      $display("FAIL zero_data: L=%h R=%h expected 0000 0000", data_L, data_R);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    test_zero_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
